// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode map, decode helpers and default load latency for the hazard scoreboard
package hazard_pkg;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDD  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_STD  = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_STI  = 4'hE;
  function automatic logic f_uses_ra(input logic [3:0] op);
    return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                      OP_LDI, OP_STD, OP_PUSH, OP_STI};
  endfunction
  function automatic logic f_uses_rb(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STI};
  endfunction
  function automatic logic f_is_load(input logic [3:0] op);
    return op inside {OP_LDD, OP_LDI, OP_POP};
  endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's load countdown; set wins, then hold, then decrement to zero
module hazard_sb_entry #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic hold_i,
  input  logic dec_i,
  output logic busy_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = set_i ? CNT_W'(LOAD_LAT) :
                      (dec_i && !hold_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign busy_o = cnt_q != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register load-use countdown scoreboard driving PC / IF/ID / ID/EX stall control
// Optional HAZ_PERF_CNT_EN adds bubble_count and max_stall performance outputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_IDX_W = $clog2(NUM_REGS),
  parameter int unsigned LOAD_LAT  = DEF_LOAD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_kill,
  input  logic [REG_IDX_W-1:0] id_ra,
  input  logic [REG_IDX_W-1:0] id_rb,
  input  logic                 id_uses_ra,
  input  logic                 id_uses_rb,
  input  logic                 id_is_load,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 mem_wait,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_flush,
  output logic [NUM_REGS-1:0]  pending_mask
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]          bubble_count,
  output logic [3:0]           max_stall
`endif
);
  localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);
  logic live, hazard, issue;
  assign live   = id_valid && !id_kill;
  assign hazard = live && ((id_uses_ra && pending_mask[id_ra]) ||
                           (id_uses_rb && pending_mask[id_rb]));
  assign issue  = live && !hazard && !mem_wait;
  assign pc_stall    = hazard;
  assign if_id_stall = hazard;
  // While mem_wait freezes ID/EX the memory-stall path already holds it, so no bubble.
  assign id_ex_flush = hazard && !mem_wait;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
    hazard_sb_entry #(.LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .set_i  (issue && id_is_load && id_rd == REG_IDX_W'(i)),
      .hold_i (mem_wait),
      .dec_i  (!mem_wait),
      .busy_o (pending_mask[i])
    );
  end
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] bubble_q, bubble_d;
  logic [3:0]  run_q, run_d, max_q, max_d;
  always_comb begin
    bubble_d = (id_ex_flush && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;
    run_d    = !hazard ? 4'd0 : (run_q == 4'hF) ? run_q : run_q + 4'd1;
    max_d    = (run_d > max_q) ? run_d : max_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bubble_q <= '0;
      run_q    <= '0;
      max_q    <= '0;
    end else begin
      bubble_q <= bubble_d;
      run_q    <= run_d;
      max_q    <= max_d;
    end
  assign bubble_count = bubble_q;
  assign max_stall    = max_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of the scoreboard at LOAD_LAT 1, 2 and 3
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_kill = 0, id_uses_ra = 0, id_uses_rb = 0, id_is_load = 0, mem_wait = 0;
  logic [1:0] id_ra = 0, id_rb = 0, id_rd = 0;
  logic pc1, if1, fl1, pc2, if2, fl2, pc3, if3, fl3;
  logic [3:0] pm1, pm2, pm3;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] bc1, bc2, bc3;
  logic [3:0]  ms1, ms2, ms3;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hazard_scoreboard #(.NUM_REGS(4), .LOAD_LAT(1)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_is_load(id_is_load), .id_rd(id_rd),
    .mem_wait(mem_wait), .pc_stall(pc1), .if_id_stall(if1), .id_ex_flush(fl1), .pending_mask(pm1)
`ifdef HAZ_PERF_CNT_EN
    , .bubble_count(bc1), .max_stall(ms1)
`endif
  );
  hazard_scoreboard #(.NUM_REGS(4), .LOAD_LAT(2)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_is_load(id_is_load), .id_rd(id_rd),
    .mem_wait(mem_wait), .pc_stall(pc2), .if_id_stall(if2), .id_ex_flush(fl2), .pending_mask(pm2)
`ifdef HAZ_PERF_CNT_EN
    , .bubble_count(bc2), .max_stall(ms2)
`endif
  );
  hazard_scoreboard #(.NUM_REGS(4), .LOAD_LAT(3)) d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_is_load(id_is_load), .id_rd(id_rd),
    .mem_wait(mem_wait), .pc_stall(pc3), .if_id_stall(if3), .id_ex_flush(fl3), .pending_mask(pm3)
`ifdef HAZ_PERF_CNT_EN
    , .bubble_count(bc3), .max_stall(ms3)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] st(input int n);
    return n == 1 ? {pc1, if1, fl1, pm1} : n == 2 ? {pc2, if2, fl2, pm2} : {pc3, if3, fl3, pm3};
  endfunction
  task automatic exp_st(input int n, input string tag, input logic pc, input logic fl, input logic [3:0] m);
    chk(tag, {25'd0, st(n)}, {25'd0, pc, pc, fl, m});
  endtask
  task automatic drv(input logic v, input logic k, input logic [1:0] ra, input logic [1:0] rb,
                     input logic ua, input logic ub, input logic ld, input logic [1:0] rd, input logic mw);
    id_valid = v; id_kill = k; id_ra = ra; id_rb = rb; id_uses_ra = ua; id_uses_rb = ub;
    id_is_load = ld; id_rd = rd; mem_wait = mw;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic load(input logic [1:0] rd);
    drv(1, 0, 0, 0, 0, 0, 1, rd, 0);
  endtask
  task automatic use_a(input logic [1:0] ra);
    drv(1, 0, ra, 0, 1, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    idle();
    step();
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    idle();
    step();
    step();
    exp_st(1, "rst_d1", 0, 0, 0);
    exp_st(2, "rst_d2", 0, 0, 0);
    exp_st(3, "rst_d3", 0, 0, 0);
    rst = 0;
    // LOAD_LAT=1: legacy single bubble
    load(2); exp_st(1, "a_ld", 0, 0, 4'b0000); step();
    use_a(2); exp_st(1, "a_stall", 1, 1, 4'b0100); step();
    exp_st(1, "a_go", 0, 0, 4'b0000); step();
    idle();
    // LOAD_LAT=3: consumer at k=1 sees 3 bubbles
    do_reset();
    load(1); step();
    use_a(1);
    for (int i = 0; i < 3; i++) begin exp_st(3, "b_k1", 1, 1, 4'b0010); step(); end
    exp_st(3, "b_k1_go", 0, 0, 4'b0000); step();
    idle();
`ifdef HAZ_PERF_CNT_EN
    chk("b_max_stall", {28'd0, ms3}, 3);
    chk("b_bubbles", {16'd0, bc3}, 3);
`endif
    // LOAD_LAT=3: consumer at k=2 sees 2 bubbles
    do_reset();
    load(1); step();
    idle(); exp_st(3, "b_gap", 0, 0, 4'b0010); step();
    use_a(1);
    for (int i = 0; i < 2; i++) begin exp_st(3, "b_k2", 1, 1, 4'b0010); step(); end
    exp_st(3, "b_k2_go", 0, 0, 4'b0000); step();
    // LOAD_LAT=3: unrelated register has no hazard
    do_reset();
    load(1); step();
    use_a(0); exp_st(3, "b_r0", 0, 0, 4'b0010); step();
    idle();
    // LOAD_LAT=2: mem_wait freezes the countdown and suppresses bubbles
    do_reset();
    load(3); step();
    drv(1, 0, 3, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin exp_st(2, "c_wait", 1, 0, 4'b1000); step(); end
    use_a(3);
    for (int i = 0; i < 2; i++) begin exp_st(2, "c_bub", 1, 1, 4'b1000); step(); end
    exp_st(2, "c_go", 0, 0, 4'b0000); step();
    idle();
    // LOAD_LAT=3: WAW reload, consumer reads the register on both ports
    do_reset();
    load(2); step();
    load(2); exp_st(3, "d_reld", 0, 0, 4'b0100); step();
    drv(1, 0, 2, 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin exp_st(3, "d_waw", 1, 1, 4'b0100); step(); end
    exp_st(3, "d_go", 0, 0, 4'b0000); step();
    idle();
    // killed slot: no stall, no set; then async reset mid-stall
    do_reset();
    load(1); step();
    drv(1, 1, 1, 0, 1, 0, 1, 2, 0); exp_st(3, "e_kill", 0, 0, 4'b0010); step();
    use_a(1); exp_st(3, "e_stall", 1, 1, 4'b0010);
    rst = 1; #1;
    exp_st(3, "e_rst", 0, 0, 4'b0000);
    exp_st(1, "e_rst_d1", 0, 0, 4'b0000);
    step();
    rst = 0;
    idle();
`ifdef HAZ_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load(2); step();
      use_a(2); step(); step();
    end
    idle(); step();
    chk("p_bubbles", {16'd0, bc1}, 5);
    chk("p_max_stall", {28'd0, ms1}, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
